// File: rtl/bishift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// bishift_seq_ctrl
//   Command sequencer for a bidirectional shift register (bishift_reg).
//   It accepts one shift command per cmd_valid/cmd_ready handshake. The command
//   carries a direction, a shift count and a serial bit pattern. The block then
//   drives the register's en/mode/d pins for exactly that many clocks. After the
//   shifts it captures the register contents into result and pulses done.
//
//   FSM: IDLE -> SHIFT -> SETTLE -> DONE -> IDLE
//
// Parameters
//   MSB      width of the controlled shift register
//   MAX_LEN  max shifts per command, also the width of cmd_data
//   LEN_W    width of cmd_len (2**LEN_W > MAX_LEN)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   cmd_valid  command present
//   cmd_ready  command accepted when high (IDLE and not in reset)
//   cmd_dir    shift direction, forwarded to sr_mode
//   cmd_len    shift count; values above MAX_LEN clamp to MAX_LEN
//   cmd_data   serial bits, bit k driven on shift k (LSB first)
//   sr_en      shift enable to the register
//   sr_mode    direction to the register
//   sr_d       serial data to the register
//   sr_out     parallel contents from the register
//   busy       high in every state except IDLE
//   done       one-cycle pulse when result is valid
//   result     sr_out captured at end of command, held until the next done
//   abort      (only with BISHIFT_CTRL_ABORT_EN) ends SHIFT early, result
//              still reported
//
// Build option
//   BISHIFT_CTRL_ABORT_EN  adds the abort input.
// -----------------------------------------------------------------------------
module bishift_seq_ctrl #(
    parameter int MSB     = 4,
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_dir,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               sr_en,
    output logic               sr_mode,
    output logic               sr_d,
    input  logic [MSB-1:0]     sr_out,
    output logic               busy,
    output logic               done,
    output logic [MSB-1:0]     result
`ifdef BISHIFT_CTRL_ABORT_EN
    ,
    input  logic               abort
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    logic [1:0]         state;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   len_q;
    logic [MAX_LEN-1:0] data_q;
    logic [LEN_W-1:0]   len_clamped;
    logic               accept;
    logic               abort_hit;

`ifdef BISHIFT_CTRL_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign cmd_ready   = (state == IDLE) && rst;
    assign accept      = cmd_valid && cmd_ready;
    assign len_clamped = (cmd_len > MAX_L) ? MAX_L : cmd_len;

    // Command payload: no reset needed, it is only read after an accept.
    // data_q holds the bits not yet driven. Bit 0 goes out at accept time, so
    // the rest is pre-shifted and each shift step consumes data_q[0].
    always_ff @(posedge clk) begin
        if (accept) begin
            len_q  <= len_clamped;
            data_q <= cmd_data >> 1;
        end else if (state == SHIFT && cnt < len_q) begin
            data_q <= data_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sr_en   <= 1'b0;
            sr_mode <= 1'b0;
            sr_d    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        busy    <= 1'b1;
                        sr_mode <= cmd_dir;
                        if (len_clamped != '0) begin
                            state <= SHIFT;
                            sr_en <= 1'b1;
                            sr_d  <= cmd_data[0];
                            cnt   <= LEN_W'(1);
                        end else begin
                            // Zero-length command: skip straight to reporting.
                            state <= SETTLE;
                            cnt   <= '0;
                        end
                    end
                end
                SHIFT: begin
                    // The register also shifts on this edge (sr_en is still
                    // high), so an abort seen at count n yields n shifts.
                    if (abort_hit || cnt >= len_q) begin
                        sr_en <= 1'b0;
                        sr_d  <= 1'b0;
                        state <= SETTLE;
                    end else begin
                        sr_d <= data_q[0];
                        cnt  <= cnt + LEN_W'(1);
                    end
                end
                SETTLE: begin
                    // sr_out now reflects the last shift.
                    result <= sr_out;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bishift_seq_ctrl.sv
module tb_bishift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_dir;
    logic [3:0] cmd_len;
    logic [7:0] cmd_data;
    logic       sr_en;
    logic       sr_mode;
    logic       sr_d;
    logic [3:0] sr_out;
    logic       busy;
    logic       done;
    logic [3:0] result;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Scoreboard queues: expected {mode,d} per shift cycle, and expected
    // result plus the edge index after which done must be seen.
    logic [1:0] exp_shift_q[$];
    logic [3:0] exp_res_q[$];
    int         exp_cyc_q[$];

    bishift_seq_ctrl #(.MSB(4), .MAX_LEN(8), .LEN_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .sr_en     (sr_en),
        .sr_mode   (sr_mode),
        .sr_d      (sr_d),
        .sr_out    (sr_out),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Shift register model: mode 0 shifts toward MSB with d entering at the
    // LSB, mode 1 shifts toward LSB with d entering at the MSB. It is never
    // reset, so partial shifts survive a controller reset.
    logic [3:0] sr_q = 4'h0;
    always @(posedge clk) begin
        if (sr_en) sr_q <= sr_mode ? {sr_d, sr_q[3:1]} : {sr_q[2:0], sr_d};
    end
    assign sr_out = sr_q;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (sr_en) begin
                if (exp_shift_q.size() == 0) chk("unexpected_shift", 1, 0);
                else begin
                    logic [1:0] e;
                    e = exp_shift_q.pop_front();
                    chk("sr_mode", sr_mode, e[1]);
                    chk("sr_d", sr_d, e[0]);
                end
            end
            if (done) begin
                if (exp_res_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    chk("result", result, exp_res_q.pop_front());
                    chk("done_cycle", cyc, exp_cyc_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic dir, input logic [3:0] len, input logic [7:0] data,
                        input int nshift, input logic push_res, input logic [3:0] exp_res,
                        input logic keep, output int acc_edge);
        int n;
        @(negedge clk);
        cmd_dir   = dir;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
        acc_edge = cyc;
        for (int k = 0; k < nshift; k++) exp_shift_q.push_back({dir, data[k]});
        if (push_res) begin
            exp_res_q.push_back(exp_res);
            exp_cyc_q.push_back(acc_edge + nshift + 1);
        end
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_res_q.size() != 0 || exp_shift_q.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("idle_timeout", 1, 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e1, e2;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_len   = 4'd0;
        cmd_data  = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sr_en", sr_en, 0);
        chk("rst_sr_mode", sr_mode, 0);
        chk("rst_sr_d", sr_d, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        rst = 1'b1;
        #1;
        chk("ready_after_rst", cmd_ready, 1);

        // dir=0 len=4 data=0A: d=0,1,0,1 shifted in from LSB: 0 -> 5
        send(1'b0, 4'd4, 8'h0A, 4, 1'b1, 4'h5, 1'b0, e1);
        chk("busy_in_cmd", busy, 1);
        chk("ready_in_cmd", cmd_ready, 0);
        wait_idle();

        // len=0: no shifts, result equals current contents (5)
        send(1'b1, 4'd0, 8'hFF, 0, 1'b1, 4'h5, 1'b0, e1);
        wait_idle();

        // len=12 clamps to 8 shifts of 1 -> F
        send(1'b1, 4'd12, 8'hFF, 8, 1'b1, 4'hF, 1'b0, e1);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("mode_held_idle", sr_mode, 1);
        chk("result_held", result, 4'hF);
        chk("ready_idle", cmd_ready, 1);

        // cmd_valid held: F -> E -> D, then D -> A -> 5
        send(1'b0, 4'd2, 8'h02, 2, 1'b1, 4'hD, 1'b1, e1);
        send(1'b0, 4'd2, 8'h02, 2, 1'b1, 4'h5, 1'b0, e2);
        chk("back_to_back_gap", e2 - e1, 5);
        wait_idle();

        // dir=1 len=3 data=05: d=1,0,1 from MSB: 5 -> A -> 5 -> A
        send(1'b1, 4'd3, 8'h05, 3, 1'b1, 4'hA, 1'b0, e1);
        wait_idle();

        // Reset during the second SHIFT cycle of a len=6 command
        send(1'b0, 4'd6, 8'h3F, 2, 1'b0, 4'h0, 1'b0, e1);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_sr_en", sr_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cmd_ready, 0);
        chk("midrst_result", result, 0);
        repeat (2) @(negedge clk);
        chk("midrst_no_done", done, 0);
        rst = 1'b1;
        #1;
        chk("midrst_ready_back", cmd_ready, 1);

        // Fresh command after reset: d=0,0,1,1 from LSB -> 3 regardless of start
        send(1'b0, 4'd4, 8'h0C, 4, 1'b1, 4'h3, 1'b0, e1);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("no_pending_results", exp_res_q.size(), 0);
        chk("no_pending_shifts", exp_shift_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
